// File: rtl/wishbone_sram_router.sv
// Registered Wishbone classic router: decodes one upstream request onto one of NUM_PORTS
// SRAM/ROM ports, returns registered ack/data, and reports unmapped or stalled accesses as errors.
module wishbone_sram_router #(
    parameter int NUM_PORTS = 11,
    parameter int DW = 32,
    parameter int AW = 32,
    parameter logic [NUM_PORTS*AW-1:0] BASE_ADDRS = (NUM_PORTS*AW)'({
        AW'(32'h300F_0000), AW'(32'h300E_0000), AW'(32'h300D_0000), AW'(32'h300C_0000),
        AW'(32'h300B_0000), AW'(32'h300A_0000), AW'(32'h3009_0000), AW'(32'h3008_0000),
        AW'(32'h3007_0000), AW'(32'h3006_0000), AW'(32'h3005_0000), AW'(32'h3004_0000),
        AW'(32'h3003_0000), AW'(32'h3002_0000), AW'(32'h3001_0000), AW'(32'h3000_0000)}),
    parameter logic [NUM_PORTS*AW-1:0] MASKS = {NUM_PORTS{AW'(32'hFFFF_F000)}},
    parameter int TIMEOUT = 255,
    parameter int TO_W = 8
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic                    wbs_ufp_stb_i,
    input  logic                    wbs_ufp_cyc_i,
    input  logic                    wbs_ufp_we_i,
    input  logic [DW/8-1:0]         wbs_ufp_sel_i,
    input  logic [DW-1:0]           wbs_ufp_dat_i,
    input  logic [AW-1:0]           wbs_ufp_adr_i,
    output logic                    wbs_ufp_ack_o,
    output logic                    wbs_ufp_err_o,
    output logic [DW-1:0]           wbs_ufp_dat_o,
    output logic [NUM_PORTS-1:0]    wbs_dfp_stb_o,
    output logic [NUM_PORTS-1:0]    wbs_dfp_cyc_o,
    output logic [NUM_PORTS-1:0]    wbs_dfp_we_o,
    output logic [DW/8-1:0]         wbs_dfp_sel_o,
    output logic [DW-1:0]           wbs_dfp_dat_o,
    output logic [AW-1:0]           wbs_dfp_adr_o,
    input  logic [NUM_PORTS*DW-1:0] wbs_dfp_dat_i,
    input  logic [NUM_PORTS-1:0]    wbs_dfp_ack_i,
    output logic [15:0]             err_count_o
);

    typedef enum logic [1:0] {IDLE, ACTIVE, RESP, ERR} state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [NUM_PORTS-1:0]   match;
    logic [NUM_PORTS-1:0]   hit_onehot;
    logic                   hit;
    logic                   sel_ack;
    logic [DW-1:0]          sel_dat;
    logic                   wd_expired;
    logic [TO_W-1:0]        wd_cnt;
    logic [15:0]            err_cnt;
    logic                   latch_req;
    logic                   take_ack;
    logic                   raise_err;

    // Decode stage: address compare against every window, lowest index wins
    always_comb begin
        match = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            match[i] = (wbs_ufp_adr_i & MASKS[i*AW +: AW]) == BASE_ADDRS[i*AW +: AW];
        end
    end

    assign hit_onehot = match & (~match + NUM_PORTS'(1));
    assign hit        = |match;

    // The registered one-hot strobe doubles as the selector for the returning port
    assign sel_ack = |(wbs_dfp_ack_i & wbs_dfp_stb_o);

    always_comb begin
        sel_dat = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (wbs_dfp_stb_o[i]) begin
                sel_dat = wbs_dfp_dat_i[i*DW +: DW];
            end
        end
    end

    assign wd_expired = (TIMEOUT != 0) && (wd_cnt == TO_W'(TIMEOUT - 1));

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        latch_req = 1'b0;
        take_ack  = 1'b0;
        raise_err = 1'b0;
        case (state)
            IDLE: begin
                if (wbs_ufp_cyc_i && wbs_ufp_stb_i) begin
                    if (hit) begin
                        state_nxt = ACTIVE;
                        latch_req = 1'b1;
                    end else begin
                        state_nxt = ERR;
                        raise_err = 1'b1;
                    end
                end
            end
            ACTIVE: begin
                // A vanished master cancels silently, even if the port answers this cycle
                if (!wbs_ufp_cyc_i) begin
                    state_nxt = IDLE;
                end else if (sel_ack) begin
                    state_nxt = RESP;
                    take_ack  = 1'b1;
                end else if (wd_expired) begin
                    state_nxt = ERR;
                    raise_err = 1'b1;
                end
            end
            RESP:    state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Register stage: downstream request, upstream response, watchdog
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wbs_dfp_stb_o <= '0;
            wbs_dfp_cyc_o <= '0;
            wbs_dfp_we_o  <= '0;
            wbs_dfp_sel_o <= '0;
            wbs_dfp_dat_o <= '0;
            wbs_dfp_adr_o <= '0;
            wbs_ufp_ack_o <= 1'b0;
            wbs_ufp_err_o <= 1'b0;
            wbs_ufp_dat_o <= '0;
            wd_cnt        <= '0;
        end else begin
            wbs_ufp_ack_o <= take_ack;
            wbs_ufp_err_o <= raise_err;
            if (take_ack) begin
                wbs_ufp_dat_o <= sel_dat;
            end else if (raise_err) begin
                wbs_ufp_dat_o <= '0;
            end
            if (latch_req) begin
                wbs_dfp_stb_o <= hit_onehot;
                wbs_dfp_cyc_o <= hit_onehot;
                wbs_dfp_we_o  <= wbs_ufp_we_i ? hit_onehot : '0;
                wbs_dfp_sel_o <= wbs_ufp_sel_i;
                wbs_dfp_dat_o <= wbs_ufp_dat_i;
                wbs_dfp_adr_o <= wbs_ufp_adr_i;
                wd_cnt        <= '0;
            end else if (state_nxt != ACTIVE) begin
                wbs_dfp_stb_o <= '0;
                wbs_dfp_cyc_o <= '0;
                wbs_dfp_we_o  <= '0;
            end else begin
                wd_cnt <= wd_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            err_cnt <= '0;
        end else if (raise_err && (err_cnt != 16'hFFFF)) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end

    assign err_count_o = err_cnt;

endmodule

// File: tb/tb_wishbone_sram_router.sv
// Directed bench for wishbone_sram_router: transaction-level model checked every cycle,
// plus literal expectations on latency, data, decode priority, watchdog, abort and reset.
module tb_wishbone_sram_router;

    localparam int NP = 11;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TIMEOUT = 255;
    // Port 4 is widened onto port 1's window to exercise lowest-index priority
    localparam logic [NP*AW-1:0] BASES = {
        32'h300A_0000, 32'h3009_0000, 32'h3008_0000, 32'h3007_0000, 32'h3006_0000,
        32'h3005_0000, 32'h3001_0000, 32'h3003_0000, 32'h3002_0000, 32'h3001_0000,
        32'h3000_0000};
    localparam logic [NP*AW-1:0] MASKS = {
        {6{32'hFFFF_F000}}, 32'hFFFF_0000, {4{32'hFFFF_F000}}};

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            ufp_stb = 1'b0;
    logic            ufp_cyc = 1'b0;
    logic            ufp_we = 1'b0;
    logic [3:0]      ufp_sel = '0;
    logic [DW-1:0]   ufp_dat = '0;
    logic [AW-1:0]   ufp_adr = '0;
    logic            ufp_ack;
    logic            ufp_err;
    logic [DW-1:0]   ufp_rdat;
    logic [NP-1:0]   dfp_stb;
    logic [NP-1:0]   dfp_cyc;
    logic [NP-1:0]   dfp_we;
    logic [3:0]      dfp_sel;
    logic [DW-1:0]   dfp_wdat;
    logic [AW-1:0]   dfp_adr;
    logic [NP*DW-1:0] dfp_rdat = '0;
    logic [NP-1:0]   dfp_ack = '0;
    logic [15:0]     err_count;

    int n_checks = 0;
    int n_fail = 0;

    // Model state: which port holds the open transaction (-1 none) and pending response pulses
    int          m_port = -1;
    int          m_age = 0;
    logic        m_ack = 1'b0;
    logic        m_err = 1'b0;
    logic [31:0] m_rdat = '0;
    logic [31:0] m_adr = '0;
    logic [31:0] m_wdat = '0;
    logic [3:0]  m_sel = '0;
    logic        m_we = 1'b0;
    int          m_errs = 0;
    int          cnt_base = 0;

    wishbone_sram_router #(
        .NUM_PORTS(NP), .DW(DW), .AW(AW), .BASE_ADDRS(BASES), .MASKS(MASKS),
        .TIMEOUT(TIMEOUT), .TO_W(8)
    ) u_dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_ufp_stb_i(ufp_stb), .wbs_ufp_cyc_i(ufp_cyc), .wbs_ufp_we_i(ufp_we),
        .wbs_ufp_sel_i(ufp_sel), .wbs_ufp_dat_i(ufp_dat), .wbs_ufp_adr_i(ufp_adr),
        .wbs_ufp_ack_o(ufp_ack), .wbs_ufp_err_o(ufp_err), .wbs_ufp_dat_o(ufp_rdat),
        .wbs_dfp_stb_o(dfp_stb), .wbs_dfp_cyc_o(dfp_cyc), .wbs_dfp_we_o(dfp_we),
        .wbs_dfp_sel_o(dfp_sel), .wbs_dfp_dat_o(dfp_wdat), .wbs_dfp_adr_o(dfp_adr),
        .wbs_dfp_dat_i(dfp_rdat), .wbs_dfp_ack_i(dfp_ack), .err_count_o(err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int decode(input logic [31:0] a);
        for (int i = 0; i < NP; i++) begin
            if ((a & MASKS[i*AW +: AW]) == BASES[i*AW +: AW]) return i;
        end
        return -1;
    endfunction

    function automatic logic [NP-1:0] onehot(input int p);
        logic [NP-1:0] v;
        v = '0;
        if (p >= 0) v[p] = 1'b1;
        return v;
    endfunction

    function automatic logic [15:0] exp_count();
        return (cnt_base + m_errs > 65535) ? 16'hFFFF : 16'(cnt_base + m_errs);
    endfunction

    // Transaction-level model: one open request at a time, answered by ack, timeout or abort
    always begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_port = -1;
            m_age  = 0;
            m_ack  = 1'b0;
            m_err  = 1'b0;
            m_errs = 0;
        end else if (m_ack || m_err) begin
            m_ack = 1'b0;
            m_err = 1'b0;
        end else if (m_port < 0) begin
            if (ufp_cyc && ufp_stb) begin
                if (decode(ufp_adr) >= 0) begin
                    m_port = decode(ufp_adr);
                    m_age  = 0;
                    m_adr  = ufp_adr;
                    m_we   = ufp_we;
                    m_sel  = ufp_sel;
                    m_wdat = ufp_dat;
                end else begin
                    m_err  = 1'b1;
                    m_rdat = '0;
                    m_errs++;
                end
            end
        end else if (!ufp_cyc) begin
            m_port = -1;
        end else if (dfp_ack[m_port]) begin
            m_ack  = 1'b1;
            m_rdat = dfp_rdat[m_port*DW +: DW];
            m_port = -1;
        end else if (TIMEOUT != 0 && m_age + 1 >= TIMEOUT) begin
            m_err  = 1'b1;
            m_rdat = '0;
            m_errs++;
            m_port = -1;
        end else begin
            m_age++;
        end
    end

    always begin
        @(negedge clk);
        check("cmp_dfp_stb", 64'(dfp_stb), 64'(onehot(m_port)));
        check("cmp_dfp_cyc", 64'(dfp_cyc), 64'(onehot(m_port)));
        check("cmp_dfp_we", 64'(dfp_we), 64'(m_we ? onehot(m_port) : '0));
        if (m_port >= 0) begin
            check("cmp_dfp_adr", 64'(dfp_adr), 64'(m_adr));
            check("cmp_dfp_dat", 64'(dfp_wdat), 64'(m_wdat));
            check("cmp_dfp_sel", 64'(dfp_sel), 64'(m_sel));
        end
        check("cmp_ack", 64'(ufp_ack), 64'(m_ack));
        check("cmp_err", 64'(ufp_err), 64'(m_err));
        check("cmp_err_count", 64'(err_count), 64'(exp_count()));
        if (m_ack || m_err) check("cmp_rdat", 64'(ufp_rdat), 64'(m_rdat));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [31:0] a, input logic w, input logic [3:0] s, input logic [31:0] d);
        ufp_adr = a;
        ufp_we  = w;
        ufp_sel = s;
        ufp_dat = d;
        ufp_cyc = 1'b1;
        ufp_stb = 1'b1;
    endtask

    task automatic ufp_idle();
        ufp_cyc = 1'b0;
        ufp_stb = 1'b0;
        ufp_we  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got running, expected done");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int n;
        repeat (2) tick();
        check("rst_ack", 64'(ufp_ack), 64'd0);
        check("rst_err", 64'(ufp_err), 64'd0);
        check("rst_stb", 64'(dfp_stb), 64'd0);
        check("rst_adr", 64'(dfp_adr), 64'd0);
        check("rst_rdat", 64'(ufp_rdat), 64'd0);
        check("rst_count", 64'(err_count), 64'd0);
        rst = 1'b0;
        tick();

        // Single-cycle write to port 2
        dfp_rdat[2*DW +: DW] = 32'hCAFE_0002;
        req(32'h3002_0010, 1'b1, 4'hF, 32'hDEAD_BEEF);
        tick();
        check("wr_stb", 64'(dfp_stb), 64'h004);
        check("wr_we", 64'(dfp_we), 64'h004);
        check("wr_adr", 64'(dfp_adr), 64'h3002_0010);
        check("wr_dat", 64'(dfp_wdat), 64'hDEAD_BEEF);
        check("wr_ack_early", 64'(ufp_ack), 64'd0);
        dfp_ack[2] = 1'b1;
        tick();
        check("wr_ack", 64'(ufp_ack), 64'd1);
        check("wr_stb_drop", 64'(dfp_stb), 64'd0);
        check("wr_rdat", 64'(ufp_rdat), 64'hCAFE_0002);
        dfp_ack = '0;
        ufp_idle();
        tick();
        check("wr_ack_once", 64'(ufp_ack), 64'd0);
        check("wr_count", 64'(err_count), 64'd0);
        tick();

        // Read from port 10 answered after three cycles, stray ack on port 3
        dfp_rdat[10*DW +: DW] = 32'h1234_5678;
        dfp_rdat[3*DW +: DW]  = 32'hBAD0_0003;
        dfp_ack[3] = 1'b1;
        req(32'h300A_0004, 1'b0, 4'hF, 32'h0);
        tick();
        check("rd_stb", 64'(dfp_stb), 64'h400);
        check("rd_we", 64'(dfp_we), 64'd0);
        repeat (2) tick();
        check("rd_stray_ack", 64'(ufp_ack), 64'd0);
        dfp_ack[10] = 1'b1;
        tick();
        check("rd_ack", 64'(ufp_ack), 64'd1);
        check("rd_rdat", 64'(ufp_rdat), 64'h1234_5678);
        dfp_ack = '0;
        ufp_idle();
        repeat (2) tick();

        // Unmapped address
        req(32'h3010_0000, 1'b0, 4'hF, 32'h0);
        tick();
        check("um_err", 64'(ufp_err), 64'd1);
        check("um_rdat", 64'(ufp_rdat), 64'd0);
        check("um_stb", 64'(dfp_stb), 64'd0);
        check("um_count", 64'(err_count), 64'd1);
        ufp_idle();
        tick();
        check("um_err_once", 64'(ufp_err), 64'd0);
        tick();

        // Port 5 never answers
        req(32'h3005_0000, 1'b0, 4'hF, 32'h0);
        tick();
        n = 1;
        for (int k = 0; k < 300; k++) begin
            tick();
            if (dfp_stb == '0) break;
            n++;
        end
        check("to_active_cycles", 64'(n), 64'd255);
        check("to_err", 64'(ufp_err), 64'd1);
        check("to_count", 64'(err_count), 64'd2);
        ufp_idle();
        tick();
        check("to_err_once", 64'(ufp_err), 64'd0);
        tick();

        // Port 5 answers on the expiry cycle
        dfp_rdat[5*DW +: DW] = 32'h55AA_55AA;
        req(32'h3005_0000, 1'b0, 4'hF, 32'h0);
        tick();
        repeat (254) tick();
        check("exp_still_active", 64'(dfp_stb), 64'h020);
        dfp_ack[5] = 1'b1;
        tick();
        check("exp_ack", 64'(ufp_ack), 64'd1);
        check("exp_no_err", 64'(ufp_err), 64'd0);
        check("exp_rdat", 64'(ufp_rdat), 64'h55AA_55AA);
        check("exp_count", 64'(err_count), 64'd2);
        dfp_ack = '0;
        ufp_idle();
        repeat (2) tick();

        // Overlapping windows: port 1 beats port 4
        req(32'h3001_0040, 1'b1, 4'h3, 32'hA5A5_A5A5);
        tick();
        check("ovl_stb", 64'(dfp_stb), 64'h002);
        check("ovl_sel", 64'(dfp_sel), 64'h3);
        dfp_ack[1] = 1'b1;
        tick();
        check("ovl_ack", 64'(ufp_ack), 64'd1);
        dfp_ack = '0;
        ufp_idle();
        repeat (2) tick();

        // Port-4-only address, master aborts in the second active cycle
        req(32'h3001_8000, 1'b0, 4'hF, 32'h0);
        tick();
        check("ab_stb", 64'(dfp_stb), 64'h010);
        tick();
        ufp_idle();
        tick();
        check("ab_stb_drop", 64'(dfp_stb), 64'd0);
        check("ab_cyc_drop", 64'(dfp_cyc), 64'd0);
        check("ab_no_ack", 64'(ufp_ack), 64'd0);
        check("ab_no_err", 64'(ufp_err), 64'd0);
        tick();
        check("ab_no_ack2", 64'(ufp_ack | ufp_err), 64'd0);

        // Asynchronous reset in the middle of an active transfer
        req(32'h3000_0000, 1'b1, 4'hF, 32'h1111_2222);
        tick();
        check("rs_stb_before", 64'(dfp_stb), 64'h001);
        #2;
        rst = 1'b1;
        #1;
        check("rs_stb", 64'(dfp_stb), 64'd0);
        check("rs_cyc", 64'(dfp_cyc), 64'd0);
        check("rs_we", 64'(dfp_we), 64'd0);
        check("rs_adr", 64'(dfp_adr), 64'd0);
        check("rs_ack_err", 64'({ufp_ack, ufp_err}), 64'd0);
        check("rs_count", 64'(err_count), 64'd0);
        ufp_idle();
        tick();
        rst = 1'b0;
        tick();

        // Error counter saturation, preloaded just below the ceiling
        force u_dut.err_cnt = 16'hFFFE;
        cnt_base = 32'hFFFE;
        #1;
        release u_dut.err_cnt;
        check("sat_preload", 64'(err_count), 64'hFFFE);
        for (int k = 0; k < 2; k++) begin
            tick();
            req(32'h3010_0000, 1'b0, 4'hF, 32'h0);
            tick();
            check("sat_err", 64'(ufp_err), 64'd1);
            check("sat_count", 64'(err_count), 64'hFFFF);
            ufp_idle();
            tick();
        end
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
